sys_sequencer: RTL and testbench

SYS_SEQUENCER -- requirements
Module: sys_sequencer

---
 rtl/sys_seq_pkg.sv | 22 ++
 rtl/sw_debounce_vec.sv | 47 ++++
 rtl/sys_sequencer.sv | 119 +++++++++++
 tb/tb_sys_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sys_seq_pkg.sv
// Shared state encodings and width helper for the system sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sys_seq_pkg;

    // State codes double as the status LED value, so the numbering is fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CFG       = 3'd1,
        ST_WAIT_SOF  = 3'd2,
        ST_RUN       = 3'd3,
        ST_FLUSH_ARM = 3'd4,
        ST_FLUSH     = 3'd5,
        ST_ERR       = 3'd6
    } seq_state_t;

    // Counter width for a count of n; a parameter of 1 still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce_vec.sv
// Two-flop synchroniser plus shared-counter debouncer for a switch vector.
// Latency: 2 sync clocks + 1 reload clock + DB_COUNT stable clocks to update.
// Backpressure: none; free-running on every clock.
module sw_debounce_vec
    import sys_seq_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int DB_COUNT = 1250000
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_sw,
    output logic [WIDTH-1:0] o_deb
);

    localparam int CW = cnt_w(DB_COUNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [CW-1:0]    cnt;

    // One counter serves the whole vector: any bit change restarts the stability window.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            cnt   <= '0;
            o_deb <= '0;
        end else begin
            sync1 <= i_sw;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                // Counter saturates here rather than wrapping.
                o_deb <= cand;
            end
        end
    end

endmodule

// File: rtl/sys_sequencer.sv
// Camera bring-up and pipeline-stage sequencer: config, frame sync, flush-and-reload of stage enables.
// Latency: all outputs registered; state changes one clock after the triggering input is sampled.
// Backpressure: none; i_sof is only honoured in WAIT_SOF and FLUSH_ARM.
module sys_sequencer
    import sys_seq_pkg::*;
#(
    parameter int N_STAGES     = 2,
    parameter int DB_COUNT     = 1250000,
    parameter int CFG_TIMEOUT  = 12500000,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_sof,
    input  logic                i_cfg_done,
    input  logic [N_STAGES-1:0] i_sw_en,
    input  logic [N_STAGES-1:0] i_stage_error,
    output logic                o_cfg_start,
    output logic [N_STAGES-1:0] o_stage_enable,
    output logic                o_pipe_flush,
    output logic [2:0]          o_state,
    output logic                o_cfg_error
);

    localparam int CFG_W = cnt_w(CFG_TIMEOUT);
    localparam int FL_W  = cnt_w(FLUSH_CYCLES);
    localparam logic [CFG_W-1:0] CFG_LAST = CFG_W'(CFG_TIMEOUT - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYCLES - 1);

    seq_state_t          state;
    logic [CFG_W-1:0]    cfg_cnt;
    logic [FL_W-1:0]     flush_cnt;
    logic [N_STAGES-1:0] sw_deb;

    sw_debounce_vec #(
        .WIDTH    (N_STAGES),
        .DB_COUNT (DB_COUNT)
    ) u_sw_debounce (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_sw   (i_sw_en),
        .o_deb  (sw_deb)
    );

    assign o_state = state;

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state          <= ST_IDLE;
            cfg_cnt        <= '0;
            flush_cnt      <= '0;
            o_cfg_start    <= 1'b0;
            o_pipe_flush   <= 1'b0;
            o_cfg_error    <= 1'b0;
            o_stage_enable <= '0;
        end else begin
            o_cfg_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_stage_enable <= '0;
                    cfg_cnt        <= '0;
                    o_cfg_start    <= 1'b1;
                    state          <= ST_CFG;
                end
                ST_CFG: begin
                    o_stage_enable <= '0;
                    // Done is checked first so it wins over a coincident timeout.
                    if (i_cfg_done) begin
                        o_stage_enable <= sw_deb;
                        state          <= ST_WAIT_SOF;
                    end else if (cfg_cnt == CFG_LAST) begin
                        o_cfg_error <= 1'b1;
                        state       <= ST_ERR;
                    end else begin
                        cfg_cnt <= cfg_cnt + 1'b1;
                    end
                end
                ST_WAIT_SOF: begin
                    if (i_sof) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Error-only case still flushes so the stages restart cleanly.
                    if ((sw_deb != o_stage_enable) || (|i_stage_error)) begin
                        state <= ST_FLUSH_ARM;
                    end
                end
                ST_FLUSH_ARM: begin
                    if (i_sof) begin
                        flush_cnt    <= '0;
                        o_pipe_flush <= 1'b1;
                        state        <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == FL_LAST) begin
                        // Sample the switches as late as possible so changes made while armed are kept.
                        o_pipe_flush   <= 1'b0;
                        o_stage_enable <= sw_deb;
                        state          <= ST_WAIT_SOF;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                ST_ERR: begin
                    o_cfg_error    <= 1'b1;
                    o_stage_enable <= '0;
                    o_pipe_flush   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_sequencer.sv
// Directed bench for sys_sequencer: vector table for bring-up, hand sequences for flush, error and reset.
// Latency: inputs applied 1 ns after a rising edge, outputs sampled 1 ns after the next one.
// Backpressure: n/a.
module tb_sys_sequencer;

    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          sof;
    logic          cfg_done;
    logic [NS-1:0] sw_en;
    logic [NS-1:0] stage_err;
    logic          cfg_start;
    logic [NS-1:0] stage_en;
    logic          pipe_flush;
    logic [2:0]    state;
    logic          cfg_error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sys_sequencer #(
        .N_STAGES     (NS),
        .DB_COUNT     (4),
        .CFG_TIMEOUT  (100),
        .FLUSH_CYCLES (3)
    ) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_sof          (sof),
        .i_cfg_done     (cfg_done),
        .i_sw_en        (sw_en),
        .i_stage_error  (stage_err),
        .o_cfg_start    (cfg_start),
        .o_stage_enable (stage_en),
        .o_pipe_flush   (pipe_flush),
        .o_state        (state),
        .o_cfg_error    (cfg_error)
    );

    typedef struct {
        logic          rstn;
        logic          sof;
        logic          cfg_done;
        logic [NS-1:0] sw;
        logic [NS-1:0] err;
        logic [2:0]    st;
        logic          cs;
        logic [NS-1:0] en;
        logic          fl;
        logic          ce;
    } vec_t;

    vec_t tbl [15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int cs, input int en,
                           input int fl, input int ce);
        chk({tag, ".state"}, int'(state), st);
        chk({tag, ".cfg_start"}, int'(cfg_start), cs);
        chk({tag, ".enable"}, int'(stage_en), en);
        chk({tag, ".flush"}, int'(pipe_flush), fl);
        chk({tag, ".cfg_error"}, int'(cfg_error), ce);
    endtask

    initial begin
        // Bring-up: reset, debounce of 101, sof ignored in CFG, done on the tenth CFG clock.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 3'b101, 3'b000, 3'd0, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 3'b101, 3'b000, 3'd0, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'b101, 3'b000, 3'd1, 1'b1, 3'b000, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'b101, 3'b000, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 3'b101, 3'b000, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 3'b101, 3'b000, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'b101, 3'b000, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'b101, 3'b000, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 3'b101, 3'b000, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'b101, 3'b000, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 3'b101, 3'b000, 3'd1, 1'b0, 3'b000, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 3'b101, 3'b000, 3'd2, 1'b0, 3'b101, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 3'b101, 3'b000, 3'd2, 1'b0, 3'b101, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 3'b101, 3'b000, 3'd3, 1'b0, 3'b101, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 3'b101, 3'b000, 3'd3, 1'b0, 3'b101, 1'b0, 1'b0};

        rstn = 1'b0; sof = 1'b0; cfg_done = 1'b0; sw_en = 3'b101; stage_err = '0;
        #1;

        for (int i = 0; i < 15; i++) begin
            rstn      = tbl[i].rstn;
            sof       = tbl[i].sof;
            cfg_done  = tbl[i].cfg_done;
            sw_en     = tbl[i].sw;
            stage_err = tbl[i].err;
            step();
            chk_all($sformatf("vec%0d", i), int'(tbl[i].st), int'(tbl[i].cs),
                    int'(tbl[i].en), int'(tbl[i].fl), int'(tbl[i].ce));
        end

        // Two-clock glitch to 111 must not reach the debounced vector.
        sw_en = 3'b111;
        step();
        step();
        sw_en = 3'b101;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("glitch%0d.state", i), int'(state), 3);
            chk($sformatf("glitch%0d.flush", i), int'(pipe_flush), 0);
        end

        // Held 111: sync 2 + reload 1 + 4 stable clocks, then RUN reacts one clock later.
        sw_en = 3'b111;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk($sformatf("hold%0d.state", i), int'(state), 3);
        end
        step();
        chk("hold8.state", int'(state), 4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("arm%0d.state", i), int'(state), 4);
            chk($sformatf("arm%0d.flush", i), int'(pipe_flush), 0);
        end
        sof = 1'b1;
        step();
        sof = 1'b0;
        chk_all("swfl1", 5, 0, 3'b101, 1, 0);
        step();
        chk_all("swfl2", 5, 0, 3'b101, 1, 0);
        step();
        chk_all("swfl3", 5, 0, 3'b101, 1, 0);
        step();
        chk_all("swfl_end", 2, 0, 3'b111, 0, 0);
        sof = 1'b1;
        step();
        sof = 1'b0;
        chk("swfl_run.state", int'(state), 3);

        // Stage error with unchanged switches: flush and reload the same enables.
        stage_err = 3'b010;
        step();
        stage_err = 3'b000;
        chk("err_arm.state", int'(state), 4);
        step();
        chk("err_arm2.state", int'(state), 4);
        sof = 1'b1;
        step();
        sof = 1'b0;
        chk_all("errfl1", 5, 0, 3'b111, 1, 0);
        step();
        step();
        chk_all("errfl3", 5, 0, 3'b111, 1, 0);
        step();
        chk_all("errfl_end", 2, 0, 3'b111, 0, 0);
        sof = 1'b1;
        step();
        sof = 1'b0;
        chk("errfl_run.state", int'(state), 3);

        // Reset in the middle of a flush.
        stage_err = 3'b001;
        step();
        stage_err = 3'b000;
        sof = 1'b1;
        step();
        sof = 1'b0;
        chk("rstfl1.flush", int'(pipe_flush), 1);
        step();
        chk("rstfl2.flush", int'(pipe_flush), 1);
        rstn = 1'b0;
        step();
        chk_all("rst_mid", 0, 0, 0, 0, 0);
        rstn = 1'b1;
        step();
        chk_all("rst_rel1", 1, 1, 0, 0, 0);
        step();
        chk_all("rst_rel2", 1, 0, 0, 0, 0);

        // Configuration timeout: 100 CFG clocks, then ERR.
        rstn = 1'b0;
        step();
        chk("to_rst.state", int'(state), 0);
        rstn = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
        end
        chk("to_100.state", int'(state), 1);
        chk("to_100.cfg_error", int'(cfg_error), 0);
        step();
        chk_all("to_err", 6, 0, 0, 0, 1);
        sof = 1'b1;
        cfg_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("err_hold%0d", i), 6, 0, 0, 0, 1);
        end
        sof = 1'b0;
        cfg_done = 1'b0;

        // Done on the timeout clock wins.
        rstn = 1'b0;
        step();
        chk_all("race_rst", 0, 0, 0, 0, 0);
        rstn = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
        end
        cfg_done = 1'b1;
        step();
        cfg_done = 1'b0;
        chk("race.state", int'(state), 2);
        chk("race.cfg_error", int'(cfg_error), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
